// File: rtl/multdiv_stage_if.sv
// Handshake between the DX pipeline stage and the multi-cycle multiply/divide unit.
interface multdiv_stage_if;
  logic        rtype_dx;
  logic        mult_dx;
  logic        div_dx;
  logic [31:0] read1_dx;
  logic [31:0] read2_dx;
  logic [4:0]  rd_dx;
  logic        flush;
  logic        stall_dx;
  logic        md_ready;
  logic [31:0] md_result;
  logic [4:0]  md_rd;
  logic        md_exception;

  modport master (
    output rtype_dx, mult_dx, div_dx, read1_dx, read2_dx, rd_dx, flush,
    input  stall_dx, md_ready, md_result, md_rd, md_exception
  );

  modport slave (
    input  rtype_dx, mult_dx, div_dx, read1_dx, read2_dx, rd_dx, flush,
    output stall_dx, md_ready, md_result, md_rd, md_exception
  );
endinterface

// File: rtl/multdiv_stage.sv
// 32-cycle signed multiply (radix-2 Booth) / divide (restoring, on magnitudes) unit.
// state | meaning: IDLE wait for req | RUN one iteration per cycle | DONE result pulse
module multdiv_stage (
  input  logic          clk,
  input  logic          reset,
  multdiv_stage_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic        op_mult;
  logic [31:0] opnd;
  logic [32:0] acc;
  logic [31:0] lo;
  logic        q1;
  logic        neg;
  logic        div_zero;
  logic        div_ovf;
  logic [4:0]  rd_q;
  logic [31:0] result_q;
  logic [4:0]  md_rd_q;
  logic        exc_q;

  logic        req;
  logic        start;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] booth_sum;
  logic [32:0] sh;
  logic [33:0] trial;
  logic [32:0] nxt_acc;
  logic [31:0] nxt_lo;
  logic        nxt_q1;
  logic [31:0] fin_result;
  logic        fin_exc;

  assign req   = bus.rtype_dx & (bus.mult_dx | bus.div_dx);
  assign start = (state == IDLE) & req & ~bus.flush;
  assign a_mag = bus.read1_dx[31] ? -bus.read1_dx : bus.read1_dx;
  assign b_mag = bus.read2_dx[31] ? -bus.read2_dx : bus.read2_dx;

  // acc is the Booth high half (33 bits so adding/subtracting -2^31 cannot wrap)
  // or the division partial remainder; lo holds multiplier or quotient bits.
  always_comb begin
    booth_sum = acc;
    case ({lo[0], q1})
      2'b01:   booth_sum = acc + {opnd[31], opnd};
      2'b10:   booth_sum = acc - {opnd[31], opnd};
      default: booth_sum = acc;
    endcase
    sh    = {acc[31:0], lo[31]};
    trial = {1'b0, sh} - {2'b00, opnd};
    if (op_mult) begin
      nxt_acc = {booth_sum[32], booth_sum[32:1]};
      nxt_lo  = {booth_sum[0], lo[31:1]};
      nxt_q1  = lo[0];
    end else begin
      nxt_acc = trial[33] ? sh : trial[32:0];
      nxt_lo  = {lo[30:0], ~trial[33]};
      nxt_q1  = 1'b0;
    end
  end

  always_comb begin
    fin_result = 32'd0;
    fin_exc    = 1'b0;
    if (op_mult) begin
      fin_result = nxt_lo;
      fin_exc    = (nxt_acc[31:0] != {32{nxt_lo[31]}});
    end else if (div_zero) begin
      fin_result = 32'd0;
      fin_exc    = 1'b1;
    end else if (div_ovf) begin
      fin_result = 32'h8000_0000;
      fin_exc    = 1'b1;
    end else begin
      fin_result = neg ? -nxt_lo : nxt_lo;
      fin_exc    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      op_mult  <= 1'b0;
      opnd     <= 32'd0;
      acc      <= 33'd0;
      lo       <= 32'd0;
      q1       <= 1'b0;
      neg      <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
      rd_q     <= 5'd0;
      result_q <= 32'd0;
      md_rd_q  <= 5'd0;
      exc_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_mult  <= bus.mult_dx;
            opnd     <= bus.mult_dx ? bus.read1_dx : b_mag;
            lo       <= bus.mult_dx ? bus.read2_dx : a_mag;
            acc      <= 33'd0;
            q1       <= 1'b0;
            neg      <= bus.read1_dx[31] ^ bus.read2_dx[31];
            div_zero <= (bus.read2_dx == 32'd0);
            div_ovf  <= (bus.read1_dx == 32'h8000_0000) & (bus.read2_dx == 32'hFFFF_FFFF);
            rd_q     <= bus.rd_dx;
            cnt      <= 5'd0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            acc <= nxt_acc;
            lo  <= nxt_lo;
            q1  <= nxt_q1;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              result_q <= fin_result;
              md_rd_q  <= rd_q;
              exc_q    <= fin_exc;
              state    <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stall_dx     = req & ~reset & ~bus.flush & (state != DONE);
  assign bus.md_ready     = (state == DONE) & ~bus.flush;
  assign bus.md_result    = result_q;
  assign bus.md_rd        = md_rd_q;
  assign bus.md_exception = exc_q;

endmodule

// File: tb/tb_multdiv_stage.sv
// Bench for multdiv_stage: vector table with scoreboard plus flush/reset corner sequences.
module tb_multdiv_stage;

  logic clk;
  logic reset;
  multdiv_stage_if bus ();

  multdiv_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_mult;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        exc;
  } exp_t;

  vec_t vecs [12];
  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic drive(input logic m, input logic rt, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    bus.rtype_dx = rt;
    bus.mult_dx  = m;
    bus.div_dx   = ~m;
    bus.read1_dx = a;
    bus.read2_dx = b;
    bus.rd_dx    = rd;
  endtask

  task automatic idle_inputs();
    bus.rtype_dx = 1'b0;
    bus.mult_dx  = 1'b0;
    bus.div_dx   = 1'b0;
  endtask

  // Counts cycles from the drive point until md_ready, bounded.
  task automatic wait_ready(output int n, output logic stall_ok);
    n = 0;
    stall_ok = 1'b1;
    @(negedge clk);
    while (!bus.md_ready && n < 100) begin
      if (!bus.stall_dx) stall_ok = 1'b0;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic watch(input int cycles, output logic saw_ready, output logic saw_stall);
    saw_ready = 1'b0;
    saw_stall = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (bus.md_ready) saw_ready = 1'b1;
      if (bus.stall_dx) saw_stall = 1'b1;
    end
  endtask

  initial begin
    int     n;
    logic   stall_ok;
    logic   saw_r;
    logic   saw_s;
    longint t_prev;
    longint t_now;
    exp_t   e;

    vecs[0]  = '{1'b1, 32'd7,          32'hFFFF_FFFA, 5'd5,  32'hFFFF_FFD6, 1'b0};
    vecs[1]  = '{1'b1, 32'h0001_0000,  32'h0001_0000, 5'd6,  32'h0000_0000, 1'b1};
    vecs[2]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{1'b0, 32'd9,          32'd0,         5'd8,  32'h0000_0000, 1'b1};
    vecs[4]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 5'd9,  32'h8000_0000, 1'b1};
    vecs[5]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1'b1};
    vecs[6]  = '{1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFB, 5'd11, 32'h0000_000F, 1'b0};
    vecs[7]  = '{1'b0, 32'd100,        32'hFFFF_FFF9, 5'd12, 32'hFFFF_FFF2, 1'b0};
    vecs[8]  = '{1'b0, 32'h7FFF_FFFF,  32'd1,         5'd13, 32'h7FFF_FFFF, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_FFFF,  32'h0000_FFFF, 5'd14, 32'hFFFE_0001, 1'b1};
    vecs[10] = '{1'b0, 32'd5,          32'd7,         5'd15, 32'h0000_0000, 1'b0};
    vecs[11] = '{1'b0, 32'hFFFF_FF9C,  32'hFFFF_FFF6, 5'd31, 32'h0000_000A, 1'b0};

    bus.flush = 1'b0;
    bus.read1_dx = 32'd0;
    bus.read2_dx = 32'd0;
    bus.rd_dx = 5'd0;
    idle_inputs();
    reset = 1'b1;
    drive(1'b1, 1'b1, 32'd7, 32'd3, 5'd3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_stall", 32'(bus.stall_dx), 32'd0);
    chk("reset_ready", 32'(bus.md_ready), 32'd0);
    chk("reset_result", bus.md_result, 32'd0);
    chk("reset_rd", 32'(bus.md_rd), 32'd0);
    chk("reset_exc", 32'(bus.md_exception), 32'd0);
    idle_inputs();
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // Vectors issued back to back: each new instruction appears right after DONE.
    t_prev = 0;
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].is_mult, 1'b1, vecs[i].a, vecs[i].b, vecs[i].rd);
      sb.push_back('{vecs[i].res, vecs[i].rd, vecs[i].exc});
      wait_ready(n, stall_ok);
      t_now = $time;
      chk($sformatf("latency[%0d]", i), 32'(n), 32'd33);
      chk($sformatf("stall_run[%0d]", i), 32'(stall_ok), 32'd1);
      chk($sformatf("stall_done[%0d]", i), 32'(bus.stall_dx), 32'd0);
      if (bus.md_ready) begin
        e = sb.pop_front();
        chk($sformatf("result[%0d]", i), bus.md_result, e.res);
        chk($sformatf("rd[%0d]", i), 32'(bus.md_rd), 32'(e.rd));
        chk($sformatf("exc[%0d]", i), 32'(bus.md_exception), 32'(e.exc));
      end else begin
        chk($sformatf("ready_timeout[%0d]", i), 32'(bus.md_ready), 32'd1);
      end
      if (i > 0) chk($sformatf("gap[%0d]", i), 32'(t_now - t_prev), 32'd340);
      t_prev = t_now;
      @(posedge clk);
      #1;
    end
    idle_inputs();

    // Non R-type with matching ALUop bits: no stall, no operation.
    drive(1'b1, 1'b0, 32'd7, 32'd6, 5'd2);
    watch(40, saw_r, saw_s);
    chk("nonr_ready", 32'(saw_r), 32'd0);
    chk("nonr_stall", 32'(saw_s), 32'd0);
    idle_inputs();
    @(posedge clk);
    #1;

    // Flush in RUN cycle 10: abort, outputs keep the previous result.
    drive(1'b1, 1'b1, 32'd3, 32'd5, 5'd9);
    repeat (10) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_run_stall", 32'(bus.stall_dx), 32'd0);
    chk("flush_run_ready", 32'(bus.md_ready), 32'd0);
    @(posedge clk);
    #1 bus.flush = 1'b0;
    idle_inputs();
    watch(40, saw_r, saw_s);
    chk("flush_run_no_pulse", 32'(saw_r), 32'd0);
    chk("flush_run_hold_result", bus.md_result, vecs[11].res);
    chk("flush_run_hold_rd", 32'(bus.md_rd), 32'(vecs[11].rd));
    @(posedge clk);
    #1;

    // A fresh op after the flush still takes the full latency.
    drive(1'b0, 1'b1, 32'd20, 32'd3, 5'd12);
    wait_ready(n, stall_ok);
    chk("after_flush_latency", 32'(n), 32'd33);
    chk("after_flush_result", bus.md_result, 32'd6);
    chk("after_flush_rd", 32'(bus.md_rd), 32'd12);
    @(posedge clk);
    #1 idle_inputs();
    @(posedge clk);
    #1;

    // Flush landing in the DONE cycle suppresses the pulse.
    drive(1'b1, 1'b1, 32'd4, 32'd4, 5'd4);
    repeat (33) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_done_ready", 32'(bus.md_ready), 32'd0);
    @(posedge clk);
    #1 bus.flush = 1'b0;
    idle_inputs();
    watch(40, saw_r, saw_s);
    chk("flush_done_no_pulse", 32'(saw_r), 32'd0);
    @(posedge clk);
    #1;

    // Reset in RUN cycle 20: everything cleared, no pulse.
    drive(1'b1, 1'b1, 32'd7, 32'hFFFF_FFFA, 5'd5);
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("reset_run_stall", 32'(bus.stall_dx), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("reset_run_result", bus.md_result, 32'd0);
    chk("reset_run_rd", 32'(bus.md_rd), 32'd0);
    chk("reset_run_exc", 32'(bus.md_exception), 32'd0);
    watch(40, saw_r, saw_s);
    chk("reset_run_no_pulse", 32'(saw_r), 32'd0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multdiv_stage.md
MULTDIV_STAGE -- requirements
Module: multdiv_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: rise  in  1  clock, all state updates on its rising edge; reset  in  1  synchronous active-high reset.
REQ-002 rtype_dx  in  1  decoded R-type opcode of the instruction currently held in the DX register.
REQ-003 mult_dx  in  1  ALUop decode equals mult (00110).
REQ-004 div_dx  in  1  ALUop decode equals div (00111).
REQ-005 read1_dx  in  32  operand A (rs value): multiplicand or dividend.
REQ-006 read2_dx  in  32  operand B (rt value): multiplier or divisor.
REQ-007 rd_dx  in  5  destination register of the DX instruction.
REQ-008 flush  in  1  abort request from branch/jump resolution.
REQ-009 stall_dx  out  1  hold request to the DX register and upstream stages.
REQ-010 md_ready  out  1  one-cycle pulse: result, rd and exception valid.
REQ-011 md_result  out  32  low 32 bits of product, or quotient.
REQ-012 md_rd  out  5  latched destination register.
REQ-013 md_exception  out  1  overflow / divide-by-zero flag, valid with md_ready.

Function
REQ-014 req SHALL be defined as rtype_dx & (mult_dx | div_dx); mult_dx and div_dx alone SHALL NOT start an operation.
REQ-015 FSM states SHALL be IDLE, RUN, DONE.
REQ-016 IDLE: when req is 1 and flush is 0, the block SHALL latch read1_dx, read2_dx, rd_dx and the op type (mult when mult_dx is 1, else div), clear the iteration counter to 0, and go to RUN at the next edge.
REQ-017 RUN SHALL perform one radix-2 iteration per cycle for exactly 32 cycles (counter 0..31), then go to DONE.
REQ-018 Multiply SHALL be signed 32x32 Booth. md_result = product[31:0]. md_exception = 1 when product[63:32] is not all copies of product[31].
REQ-019 Divide SHALL be signed, truncating toward zero, with the remainder discarded; the iteration SHALL operate on magnitudes with sign correction in DONE.
REQ-020 Divisor 0: md_result SHALL be 0 and md_exception 1; the block SHALL still take the full 32 RUN cycles.
REQ-021 0x80000000 / 0xFFFFFFFF: md_result SHALL be 0x80000000 and md_exception 1.
REQ-022 DONE SHALL last one cycle with md_ready=1, then return to IDLE; a req seen in DONE SHALL NOT start a new operation.
REQ-023 stall_dx SHALL be combinational, = req & ~reset & ~flush & (state != DONE). The DX instruction therefore advances at the DONE-cycle edge and is consumed exactly once.
REQ-024 Latency: with req first seen in IDLE in cycle 0, RUN SHALL occupy cycles 1..32, DONE cycle 33; stall_dx SHALL be 1 in cycles 0..32 and 0 in cycle 33.
REQ-025 md_result, md_rd and md_exception SHALL hold their last value until the next DONE; md_ready SHALL be 0 outside DONE.
REQ-026 flush in RUN or DONE SHALL return the FSM to IDLE at the next edge with no md_ready pulse; flush in IDLE SHALL suppress the start.
REQ-027 Flush while in DONE SHALL force md_ready to 0 in that cycle.

Reset
REQ-028 reset SHALL, at the next rising edge, force state IDLE, counter 0, and md_result, md_rd, md_exception, md_ready and all latched operands to 0.
REQ-029 stall_dx SHALL be 0 in any cycle where reset is 1.
REQ-030 Reset during RUN SHALL abandon the operation with no md_ready pulse.

Verification
REQ-031 mult: A=7, B=-6, rd=5 -> stall_dx high for 33 cycles; in cycle 33 md_ready=1, md_result=0xFFFFFFD6, md_rd=5, md_exception=0.
REQ-032 mult overflow: A=0x00010000, B=0x00010000 -> md_result=0, md_exception=1.
REQ-033 div: A=-7, B=2 -> md_result=0xFFFFFFFD (-3), exception 0. Divide by zero: A=9, B=0 -> md_result=0, exception 1, same 33-cycle latency.
REQ-034 Back-to-back ops: mult followed immediately by div in DX -> two separate md_ready pulses 34 cycles apart, with no operation lost or duplicated.
REQ-035 flush in cycle 10 of RUN -> IDLE next cycle, no md_ready pulse, stall_dx 0. Reset in cycle 20 of RUN -> all outputs 0, no md_ready pulse.
REQ-036 req with rtype_dx=0 (non-R-type opcode whose bits [6:2]=00110) -> no stall and no operation.
